reg_dump_sequencer: RTL and testbench



---
 rtl/reg_dump_pkg.sv | 18 +
 rtl/reg_dump_char_mux.sv | 30 +++
 rtl/reg_dump_sequencer.sv | 114 +++++++++++
 tb/tb_reg_dump_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared FSM states, ASCII constants and hex formatting for reg_dump_sequencer.
package reg_dump_pkg;

    typedef enum logic [1:0] {IDLE, SELECT, SEND, DONE} state_t;

    localparam logic [7:0] ASCII_X  = 8'h78;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam int LINE_LEN = 14;

    function automatic logic [7:0] nibble_ascii(input logic [3:0] n);
        return (n < 4'd10) ? ASCII_0 + {4'b0, n} : ASCII_A + {4'b0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/reg_dump_char_mux.sv
// reg_dump_char_mux: picks the ASCII byte of a dump line "xNN=HHHHHHHH\r\n" for a char position.
module reg_dump_char_mux
    import reg_dump_pkg::*;
(
    input  logic [3:0]  iChar,
    input  logic [4:0]  iIdx,
    input  logic [31:0] iSnap,
    output logic [7:0]  oChar
);

    logic [1:0] tens;
    logic [4:0] ones;
    logic [2:0] nib_sel;
    logic [3:0] nib;

    always_comb begin
        tens    = (iIdx >= 5'd30) ? 2'd3 : (iIdx >= 5'd20) ? 2'd2 : (iIdx >= 5'd10) ? 2'd1 : 2'd0;
        ones    = iIdx - {3'b0, tens} * 5'd10;
        // chars 4..11 carry nibbles 7..0 of the snapshot
        nib_sel = 3'(4'd11 - iChar);
        nib     = iSnap[{nib_sel, 2'b00} +: 4];
        oChar   = (iChar == 4'd0)  ? ASCII_X :
                  (iChar == 4'd1)  ? ASCII_0 + {6'b0, tens} :
                  (iChar == 4'd2)  ? ASCII_0 + {3'b0, ones} :
                  (iChar == 4'd3)  ? ASCII_EQ :
                  (iChar == 4'd12) ? ASCII_CR :
                  (iChar == 4'd13) ? ASCII_LF : nibble_ascii(nib);
    end

endmodule

// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer: walks registers START_REG..END_REG and streams one ASCII line each to a byte sink.
// Define REG_DUMP_SKIP_ZERO_EN to suppress lines for registers that read as zero.
module reg_dump_sequencer
    import reg_dump_pkg::*;
#(
    parameter int START_REG = 0,
    parameter int END_REG   = 31
)
(
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iStart,
    output logic        oBusy,
    output logic        oDone,
    output logic [4:0]  oRegDispSelect,
    input  logic [31:0] iRegDisp,
    output logic [7:0]  oTxData,
    output logic        oTxValid,
    input  logic        iTxReady
);

    state_t      state_q;
    logic [4:0]  idx_q;
    logic [4:0]  sel_q;
    logic [3:0]  chr_q;
    logic [31:0] snap_q;
    logic        busy_q;
    logic        done_q;
    logic        valid_q;
    logic [7:0]  mux_char;
    logic        last_reg;
    logic        line_end;
    logic        skip;

    assign last_reg = idx_q == 5'(END_REG);
    assign line_end = chr_q == 4'(LINE_LEN - 1);
`ifdef REG_DUMP_SKIP_ZERO_EN
    assign skip = iRegDisp == 32'd0;
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            sel_q   <= 5'(START_REG);
            chr_q   <= 4'd0;
            snap_q  <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (iStart) begin
                    state_q <= SELECT;
                    idx_q   <= 5'(START_REG);
                    sel_q   <= 5'(START_REG);
                    busy_q  <= 1'b1;
                end
                SELECT: begin
                    snap_q <= iRegDisp;
                    chr_q  <= 4'd0;
                    if (!skip) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                    end else if (last_reg) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                        sel_q <= idx_q + 5'd1;
                    end
                end
                SEND: if (iTxReady) begin
                    if (!line_end) begin
                        chr_q <= chr_q + 4'd1;
                    end else begin
                        // compare before incrementing so END_REG=31 never wraps
                        valid_q <= 1'b0;
                        if (last_reg) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SELECT;
                            idx_q   <= idx_q + 5'd1;
                            sel_q   <= idx_q + 5'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    reg_dump_char_mux u_char_mux (
        .iChar (chr_q),
        .iIdx  (idx_q),
        .iSnap (snap_q),
        .oChar (mux_char)
    );

    assign oBusy          = busy_q;
    assign oDone          = done_q;
    assign oRegDispSelect = sel_q;
    assign oTxValid       = valid_q;
    assign oTxData        = valid_q ? mux_char : 8'h00;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// tb_reg_dump_sequencer: scoreboard bench with a line-formatting reference model and random sink stalls.
module tb_reg_dump_sequencer;

`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic iCLK = 1'b0, iRST_n = 1'b0, iStart = 1'b0, start_b = 1'b0;
    logic iTxReady = 1'b1, rand_rdy = 1'b0;
    logic [31:0] rf [32];
    logic [31:0] mdl [32];
    logic [4:0] sel_a, sel_b, sel_c;
    logic [31:0] disp_a, disp_b, disp_c;
    logic busy_a, done_a, txv_a, busy_b, done_b, txv_b, busy_c, done_c, txv_c;
    logic [7:0] txd_a, txd_b, txd_c;
    logic [7:0] exp_q [$];
    string got_b = "", got_c = "";
    int checks = 0, fails = 0, cyc = 0, nbytes = 0, c0 = 0;
    logic stalled = 1'b0;
    logic [7:0] last_d = 8'h00;

    assign disp_a = rf[sel_a];
    assign disp_b = rf[sel_b];
    assign disp_c = rf[sel_c];

    reg_dump_sequencer u_dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .oBusy(busy_a), .oDone(done_a),
        .oRegDispSelect(sel_a), .iRegDisp(disp_a), .oTxData(txd_a), .oTxValid(txv_a), .iTxReady(iTxReady)
    );
    reg_dump_sequencer #(.START_REG(31), .END_REG(31)) u_one (
        .iCLK(iCLK), .iRST_n(iRST_n), .iStart(start_b), .oBusy(busy_b), .oDone(done_b),
        .oRegDispSelect(sel_b), .iRegDisp(disp_b), .oTxData(txd_b), .oTxValid(txv_b), .iTxReady(iTxReady)
    );
    reg_dump_sequencer #(.START_REG(10), .END_REG(12)) u_rng (
        .iCLK(iCLK), .iRST_n(iRST_n), .iStart(start_b), .oBusy(busy_c), .oDone(done_c),
        .oRegDispSelect(sel_c), .iRegDisp(disp_c), .oTxData(txd_c), .oTxValid(txv_c), .iTxReady(iTxReady)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        cyc = cyc + 1;
        #1;
        iTxReady = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic string line_of(input int i, input logic [31:0] v);
        string hx;
        hx = $sformatf("%08h", v);
        hx = hx.toupper();
        return $sformatf("x%02d=%s%c%c", i, hx, 8'h0D, 8'h0A);
    endfunction

    // expected text and cycle cost of a dump: 15 cycles per line, 1 per skipped zero
    task automatic plan(input int lo, input int hi, output string s, output int cost);
        s = "";
        cost = 0;
        for (int i = lo; i <= hi; i++) begin
            if (SKIP && mdl[i] == 32'd0) cost += 1;
            else begin
                s = $sformatf("%s%s", s, line_of(i, mdl[i]));
                cost += 15;
            end
        end
    endtask

    task automatic push_str(input string s);
        for (int j = 0; j < s.len(); j++) exp_q.push_back(s[j]);
    endtask

    always @(negedge iCLK) begin
        if (!iRST_n) stalled = 1'b0;
        else begin
            if (stalled) begin
                chk("stall_valid", 32'(txv_a), 32'd1);
                chk("stall_data", 32'(txd_a), 32'(last_d));
            end
            if (txv_a && iTxReady) begin
                nbytes++;
                chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("byte", 32'(txd_a), 32'(exp_q.pop_front()));
            end
            stalled = txv_a && !iTxReady;
            last_d = txd_a;
        end
        if (txv_b && iTxReady) got_b = $sformatf("%s%c", got_b, txd_b);
        if (txv_c && iTxReady) got_c = $sformatf("%s%c", got_c, txd_c);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic clear_regs();
        for (int i = 0; i < 32; i++) begin
            rf[i] = 32'd0;
            mdl[i] = 32'd0;
        end
    endtask

    task automatic set_reg(input int i, input logic [31:0] v);
        rf[i] = v;
        mdl[i] = v;
    endtask

    task automatic start_main();
        iStart = 1'b1;
        tick(1);
        iStart = 1'b0;
        c0 = cyc;
        chk("busy_k1", 32'(busy_a), 32'd1);
        chk("sel_k1", 32'(sel_a), 32'd0);
    endtask

    task automatic wait_done(input bit check_lat, input int cost);
        int lat;
        lat = -1;
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            if (done_a) begin
                lat = cyc - c0;
                break;
            end
        end
        chk("done_seen", 32'(lat >= 0), 32'd1);
        if (check_lat) chk("done_latency", 32'(lat), 32'(cost));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        tick(1);
        chk("done_pulse", 32'(done_a), 32'd0);
        chk("idle_busy", 32'(busy_a), 32'd0);
    endtask

    task automatic full_dump(input bit check_lat);
        string s;
        int cost;
        plan(0, 31, s, cost);
        push_str(s);
        start_main();
        wait_done(check_lat, cost);
    endtask

    initial begin
        string s, sb, sc;
        int cost, cs, target;
        bit db, dc;
        clear_regs();
        tick(2);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_valid", 32'(txv_a), 32'd0);
        chk("rst_data", 32'(txd_a), 32'd0);
        chk("rst_sel", 32'(sel_a), 32'd0);
        chk("rst_sel_one", 32'(sel_b), 32'd31);
        chk("rst_sel_rng", 32'(sel_c), 32'd10);
        chk("rst_idle_b", 32'({busy_b, busy_c, txv_b, txv_c}), 32'd0);
        iRST_n = 1'b1;
        tick(2);

        set_reg(2, 32'h00003FFC);
        set_reg(3, 32'h00001800);
        full_dump(1'b1);

        set_reg(31, 32'hDEADBEEF);
        set_reg(17, $urandom());
        rand_rdy = 1'b1;
        full_dump(1'b0);

        for (int i = 10; i <= 12; i++) set_reg(i, $urandom() | 32'h1);
        plan(31, 31, sb, cost);
        plan(10, 12, sc, cost);
        got_b = "";
        got_c = "";
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        db = 1'b0;
        dc = 1'b0;
        for (int i = 0; i < 3000 && !(db && dc); i++) begin
            tick(1);
            if (done_b) db = 1'b1;
            if (done_c) dc = 1'b1;
        end
        chk("one_done", 32'(db), 32'd1);
        chk("rng_done", 32'(dc), 32'd1);
        chk("one_text", 32'(got_b == sb), 32'd1);
        chk("one_len", 32'(got_b.len()), 32'(sb.len()));
        chk("rng_text", 32'(got_c == sc), 32'd1);
        chk("rng_len", 32'(got_c.len()), 32'(sc.len()));
        rand_rdy = 1'b0;
        tick(2);

        clear_regs();
        set_reg(2, 32'h00003FFC);
        set_reg(3, 32'h00001800);
        set_reg(5, 32'h11111111);
        plan(0, 4, s, cs);
        plan(0, 31, s, cost);
        push_str(s);
        start_main();
        target = c0 + cs + 3;
        while (cyc < target) tick(1);
        rf[5] = 32'h22222222;
        wait_done(1'b1, cost);

        rf[5] = 32'h11111111;
        mdl[5] = 32'h22222222;
        plan(0, 31, s, cost);
        push_str(s);
        start_main();
        target = c0 + cs - 1;
        while (cyc < target) tick(1);
        rf[5] = 32'h22222222;
        wait_done(1'b1, cost);

        nbytes = 0;
        plan(0, 31, s, cost);
        push_str(s);
        start_main();
        for (int i = 0; i < 2000 && nbytes < 20; i++) tick(1);
        chk("reached_20_bytes", 32'(nbytes), 32'd20);
        iRST_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(txv_a), 32'd0);
        chk("async_rst_busy", 32'(busy_a), 32'd0);
        exp_q.delete();
        tick(2);
        iRST_n = 1'b1;
        tick(1);
        chk("post_rst_char", 32'(exp_q.size()), 32'd0);
        full_dump(1'b1);

        plan(0, 31, s, cost);
        push_str(s);
        start_main();
        tick(5);
        iStart = 1'b1;
        tick(1);
        iStart = 1'b0;
        tick(10);
        iStart = 1'b1;
        tick(2);
        iStart = 1'b0;
        wait_done(1'b1, cost);
        tick(20);
        chk("no_retrigger", 32'(busy_a), 32'd0);

        clear_regs();
        full_dump(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
